i2c_master_write_bit: RTL
=========================

I2C_MASTER_WRITE_BIT -- requirements
Module: i2c_master_write_bit

Interface
REQ-001 SHALL have ports: clock  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: go  input  1  request to transmit one bit, level-sampled in IDLE.
REQ-004 SHALL have: data  input  1  bit value to transmit, captured when go is accepted.
REQ-005 SHALL have: sda_in  input  1  SDA bus readback.
REQ-006 SHALL have: scl_in  input  1  SCL bus readback; used only for clock stretching.
REQ-007 SHALL have: scl  output  1  SCL drive (1 = released/high).
REQ-008 SHALL have: sda_out  output  1  SDA drive (1 = released, 0 = pull low).
REQ-009 SHALL have: finish  output  1  one-cycle pulse, bit complete.
REQ-010 SHALL have: arb_lost  output  1  arbitration lost on the last bit; valid with finish.

Function
REQ-011 SHALL implement states IDLE, LOW, HIGH, DONE, plus a 3-bit phase counter.
REQ-012 IDLE: go=1 at edge N captures data into data_q, clears arb_lost and enters LOW with counter=0.
REQ-013 LOW: counter 0..3, scl=0; sda_out holds its previous value at counter 0 and equals data_q from counter 1 onward.
REQ-014 LOW at counter 3 -> HIGH with counter 4; HIGH: counter 4..6, scl=1, sda_out=data_q.
REQ-015 HIGH at counter 5: if data_q=1 and synchronized sda_in=0, arb_lost SHALL be set at the next edge and sda_out SHALL be released (1) from that edge.
REQ-016 HIGH at counter 6 -> DONE; DONE lasts exactly 1 cycle with finish=1 and scl=1, then -> IDLE.
REQ-017 Without stretching, finish SHALL be high between edges N+7 and N+8.
REQ-018 IDLE: scl=1, sda_out keeps its last value, finish=0.
REQ-019 go deasserted mid-bit SHALL be ignored; the bit SHALL complete.
REQ-020 go held high SHALL start the next bit after exactly one IDLE cycle following DONE.
REQ-021 data changes after capture SHALL NOT affect the bit in progress.
REQ-022 sda_in and scl_in SHALL each pass through a 2-flop synchronizer before use.
REQ-023 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-024 arb_lost SHALL hold its value until the next accepted go.

Reset
REQ-025 reset_n low SHALL asynchronously force state=IDLE, counter=0, data_q=0, scl=1, sda_out=1, finish=0, arb_lost=0, and clear both synchronizers to 1.
REQ-026 Reset asserted mid-bit SHALL abort the bit without a finish pulse; the block SHALL accept go on the first edge after release.

Configuration
REQ-027 Macro I2C_CLK_STRETCH_EN defined: in HIGH at counter 4, the counter SHALL hold while synchronized scl_in=0, extending the HIGH phase by the number of stall cycles.
REQ-028 Macro I2C_CLK_STRETCH_EN undefined: scl_in SHALL be ignored and timing SHALL be fixed per REQ-017.

Verification
REQ-029 Scenario: go=1, data=0 at edge N, sda_in follows sda_out -> scl 0 for N..N+4 and 1 for N+4..N+8; sda_out 0 from N+1; finish pulse N+7..N+8; arb_lost=0.
REQ-030 Scenario: data=1, sda_in forced 0 throughout HIGH -> arb_lost=1 by N+6, sda_out=1, finish at N+7, arb_lost still 1 after DONE.
REQ-031 Scenario: go held high, bits 1,0,1 on data -> three finish pulses spaced 9 cycles apart, sda_out pattern 1,0,1.
REQ-032 Scenario: reset_n pulsed low at counter 2 -> immediate scl=1, sda_out=1, no finish; new go after release -> normal 8-cycle bit.
REQ-033 Scenario (I2C_CLK_STRETCH_EN): scl_in held 0 for 5 cycles from HIGH entry -> finish delayed to N+12..N+13; without the macro -> finish at N+7.

Source files
------------

// File: rtl/i2c_master_write_bit.sv
// rtl/i2c_master_write_bit.sv - I2C master single-bit transmitter with arbitration check
//
// Sends one data bit per accepted go: four SCL-low phase cycles, three
// SCL-high phase cycles, then one DONE cycle that pulses finish. While SCL
// is high, a released 1 that reads back as 0 flags arbitration loss.
//
// Optional feature: define I2C_CLK_STRETCH_EN to let a slave stretch the
// high phase by holding SCL low (counter stalls at phase 4).
//
// Ports:
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   go        in   start one bit, sampled in IDLE
//   data      in   bit to send, captured when go is accepted
//   sda_in    in   SDA bus readback (synchronized internally)
//   scl_in    in   SCL bus readback, only used for clock stretching
//   scl       out  SCL drive, 1 = released
//   sda_out   out  SDA drive, 1 = released, 0 = pull low
//   finish    out  one-cycle pulse when the bit is complete
//   arb_lost  out  arbitration lost on the last bit, held until next go

module i2c_master_write_bit (
  input  logic clock,
  input  logic reset_n,
  input  logic go,
  input  logic data,
  input  logic sda_in,
  input  logic scl_in,
  output logic scl,
  output logic sda_out,
  output logic finish,
  output logic arb_lost
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic [2:0] count, count_nx;
  logic       data_q, data_q_nx;
  logic       scl_nx, sda_nx, finish_nx, arb_nx;

  // Two-flop synchronizers; reset to the idle (released) bus level.
  logic sda_s1, sda_s2;
  logic scl_s1, scl_s2;
  logic stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
    end else begin
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
    end
  end

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low keeps the counter parked at the start of HIGH.
  assign stall = ~scl_s2;
`else
  logic unused_scl_sync;
  assign unused_scl_sync = scl_s2;
  assign stall = 1'b0;
`endif

  // Outputs are registered: the combinational block computes the value each
  // output takes after the coming edge, alongside the next state.
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    data_q_nx = data_q;
    scl_nx    = scl;
    sda_nx    = sda_out;
    finish_nx = 1'b0;
    arb_nx    = arb_lost;

    case (state)
      IDLE: begin
        scl_nx = 1'b1;
        if (go) begin
          state_nx  = LOW;
          count_nx  = 3'd0;
          data_q_nx = data;
          arb_nx    = 1'b0;
          scl_nx    = 1'b0;
          // sda_out keeps its old value for phase 0 so it never changes
          // in the same cycle SCL falls.
        end
      end

      LOW: begin
        scl_nx = 1'b0;
        sda_nx = data_q;
        if (count == 3'd3) begin
          state_nx = HIGH;
          count_nx = 3'd4;
          scl_nx   = 1'b1;
        end else begin
          count_nx = count + 3'd1;
        end
      end

      HIGH: begin
        scl_nx = 1'b1;
        sda_nx = arb_lost ? 1'b1 : data_q;
        case (count)
          3'd4: begin
            if (!stall) count_nx = 3'd5;
          end
          3'd5: begin
            count_nx = 3'd6;
            // We released SDA but someone else holds it low: back off.
            if (data_q && !sda_s2) begin
              arb_nx = 1'b1;
              sda_nx = 1'b1;
            end
          end
          3'd6: begin
            state_nx  = DONE;
            count_nx  = 3'd0;
            finish_nx = 1'b1;
          end
          default: count_nx = 3'd4;
        endcase
      end

      DONE: begin
        scl_nx   = 1'b1;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
        count_nx = 3'd0;
        scl_nx   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= 3'd0;
      data_q   <= 1'b0;
      scl      <= 1'b1;
      sda_out  <= 1'b1;
      finish   <= 1'b0;
      arb_lost <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      data_q   <= data_q_nx;
      scl      <= scl_nx;
      sda_out  <= sda_nx;
      finish   <= finish_nx;
      arb_lost <= arb_nx;
    end
  end

endmodule
